// File: rtl/tri_clip_cull_if.sv
// Triangle stream bundle: valid/ready handshake carrying
// nine packed coordinates plus a colour word.
interface tri_clip_cull_if #(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 24
);
    logic                   valid;
    logic                   ready;
    logic [9*COORD_W-1:0]   vertices;
    logic [COLOR_W-1:0]     color;

    modport master (
        output valid,
        output vertices,
        output color,
        input  ready
    );

    modport slave (
        input  valid,
        input  vertices,
        input  color,
        output ready
    );
endinterface

// File: rtl/tri_clip_cull.sv
// Clip/cull stage: drops invisible triangles, clamps survivors,
// and queues them in a small FIFO ahead of rasteriser setup.
module tri_clip_cull #(
    parameter int COORD_W    = 16,
    parameter int COLOR_W    = 24,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter bit CLAMP_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    tri_clip_cull_if.slave     in_bus,
    tri_clip_cull_if.master    out_bus,
    input  logic [1:0]         cull_mode,
    output logic [CNT_W-1:0]   drop_count,
    input  logic               drop_clear
);
    localparam int VW = 9 * COORD_W;
    localparam int EW = VW + COLOR_W;
    localparam int AW = 2 * COORD_W + 4;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic signed [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);
    localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CLASSIFY,
        FACING,
        PUSH
    } state_t;

    state_t state, state_nx;

    logic                      live;
    logic [VW-1:0]             vtx;
    logic [VW-1:0]             vtx_clamp;
    logic [COLOR_W-1:0]        col;
    logic [1:0]                mode;
    logic [1:0]                mode_eff;
    logic signed [COORD_W-1:0] vx [3];
    logic signed [COORD_W-1:0] vy [3];
    logic signed [COORD_W-1:0] vz [3];
    logic [4:0]                oc [3];
    logic signed [AW-1:0]      dx1, dy1, dx2, dy2, area;
    logic                      take, cls_drop, face_drop;
    logic                      drop, push, pop, full;

    logic [EW-1:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [PW:0]               count;

    function automatic logic signed [AW-1:0] sx(
        input logic signed [COORD_W-1:0] v
    );
        return AW'(v);
    endfunction

    function automatic logic [COORD_W-1:0] clampc(
        input logic signed [COORD_W-1:0] v,
        input logic signed [COORD_W-1:0] hi
    );
        logic [COORD_W-1:0] r;
        if (v[COORD_W-1])
            r = '0;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return r;
    endfunction

    assign in_bus.ready = live && (state == IDLE);
    assign take = in_bus.valid && in_bus.ready;
    assign mode_eff = (mode == 2'd3) ? 2'd0 : mode;

    // Unpack held vertices and build per-vertex outcodes
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            vx[i] = vtx[(3*i)*COORD_W +: COORD_W];
            vy[i] = vtx[(3*i+1)*COORD_W +: COORD_W];
            vz[i] = vtx[(3*i+2)*COORD_W +: COORD_W];
            oc[i] = {vz[i][COORD_W-1], vy[i] > YMAX, vy[i][COORD_W-1],
                     vx[i] > XMAX, vx[i][COORD_W-1]};
        end
    end

    assign cls_drop = (|(oc[0] & oc[1] & oc[2])) ||
                      oc[0][4] || oc[1][4] || oc[2][4];

    // Signed doubled area; wide enough that it never overflows
    always_comb begin
        dx1  = sx(vx[1]) - sx(vx[0]);
        dy1  = sx(vy[1]) - sx(vy[0]);
        dx2  = sx(vx[2]) - sx(vx[0]);
        dy2  = sx(vy[2]) - sx(vy[0]);
        area = dx1 * dy2 - dx2 * dy1;
    end

    assign face_drop = ((area == '0) && (mode_eff != 2'd0)) ||
                       ((mode_eff == 2'd1) && area[AW-1]) ||
                       ((mode_eff == 2'd2) && !area[AW-1] && (area != '0));

    // Viewport clamp of x/y; z passes through
    always_comb begin
        vtx_clamp = vtx;
        for (int i = 0; i < 3; i++) begin
            vtx_clamp[(3*i)*COORD_W +: COORD_W]   = clampc(vx[i], XMAX);
            vtx_clamp[(3*i+1)*COORD_W +: COORD_W] = clampc(vy[i], YMAX);
        end
    end

    // State register; live keeps in_ready low until reset is over
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end
    end

    // Next state plus drop/push strobes
    always_comb begin
        state_nx = state;
        drop     = 1'b0;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                if (take)
                    state_nx = CLASSIFY;
            end
            CLASSIFY: begin
                if (cls_drop) begin
                    drop     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = FACING;
                end
            end
            FACING: begin
                if (face_drop) begin
                    drop     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = PUSH;
                end
            end
            PUSH: begin
                if (!full) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the triangle at transfer; overwrite with clamped copy
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vtx  <= '0;
            col  <= '0;
            mode <= '0;
        end else if (take) begin
            vtx  <= in_bus.vertices;
            col  <= in_bus.color;
            mode <= cull_mode;
        end else if (state == FACING && !face_drop && CLAMP_EN) begin
            vtx  <= vtx_clamp;
        end
    end

    // Saturating drop counter; clear wins over increment
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            drop_count <= '0;
        else if (drop_clear)
            drop_count <= '0;
        else if (drop && !(&drop_count))
            drop_count <= drop_count + CNT_W'(1);
    end

    assign full = (count == DEPTH);
    assign out_bus.valid = (count != '0);
    assign pop = out_bus.valid && out_bus.ready;
    assign {out_bus.vertices, out_bus.color} =
        out_bus.valid ? mem[rd_ptr] : '0;

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {vtx, col};
    end

    // FIFO pointers and occupancy; fullness sampled before any pop
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW + 1)'(1);
            else if (pop && !push)
                count <= count - (PW + 1)'(1);
        end
    end
endmodule

// File: tb/tb_tri_clip_cull.sv
// Scoreboard bench for tri_clip_cull: expected triangles are queued
// at drive time and compared as the FIFO head is popped.
module tb_tri_clip_cull;
    localparam int CW    = 16;
    localparam int KW    = 24;
    localparam int CNT_W = 12;
    localparam int TW    = 9 * CW + KW;
    localparam logic [CNT_W-1:0] MAXD = '1;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [1:0]       cull_mode = 2'd0;
    logic             drop_clear = 1'b0;
    logic [CNT_W-1:0] drop_count;

    int               checks = 0;
    int               errors = 0;
    logic [TW-1:0]    exp_q [$];
    logic [CNT_W-1:0] exp_drop = '0;

    tri_clip_cull_if #(.COORD_W(CW), .COLOR_W(KW)) in_bus ();
    tri_clip_cull_if #(.COORD_W(CW), .COLOR_W(KW)) out_bus ();

    tri_clip_cull #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_bus     (in_bus),
        .out_bus    (out_bus),
        .cull_mode  (cull_mode),
        .drop_count (drop_count),
        .drop_clear (drop_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [9*CW-1:0] pk(int x0, int y0, int x1,
                                          int y1, int x2, int y2, int z);
        return {CW'(z), CW'(y2), CW'(x2),
                CW'(z), CW'(y1), CW'(x1),
                CW'(z), CW'(y0), CW'(x0)};
    endfunction

    // Pop-side scoreboard: a head that is valid and ready leaves next edge
    always @(negedge clk) begin
        #1;
        if (n_rst && out_bus.valid && out_bus.ready) begin
            if (exp_q.size() == 0)
                chk("out_pending", exp_q.size(), 1);
            else
                chk("out_tri", {out_bus.vertices, out_bus.color},
                    exp_q.pop_front());
        end
    end

    // Offer one triangle; returns on the negedge after its transfer
    task automatic send(input logic [9*CW-1:0] v, input logic [KW-1:0] c,
                        input logic [1:0] m, input bit dropped,
                        input logic [9*CW-1:0] ev);
        int n = 0;
        in_bus.valid    = 1'b1;
        in_bus.vertices = v;
        in_bus.color    = c;
        cull_mode       = m;
        if (!dropped)
            exp_q.push_back({ev, c});
        else if (exp_drop != MAXD)
            exp_drop = exp_drop + 1'b1;
        #1;
        while (!in_bus.ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50)
            chk("send_timeout", n, 0);
        @(negedge clk);
        in_bus.valid = 1'b0;
        cull_mode = (m == 2'd2) ? 2'd1 : 2'd2;
    endtask

    // Wait until scoreboard empty and stage idle again
    task automatic drain(input string tag);
        int n = 0;
        #1;
        while ((exp_q.size() != 0 || !in_bus.ready) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, n < 200, 1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9*CW-1:0] tri_a, tri_b, tri_c, tri_off, tri_p, tri_y, tri_z;
        tri_a   = pk(10, 10, 100, 10, 10, 100, 5);
        tri_b   = pk(10, 10, 10, 100, 100, 10, 5);
        tri_c   = pk(0, 0, 5, 5, 10, 10, 5);
        tri_off = pk(700, 10, 800, 20, 650, 300, 5);
        tri_p   = pk(600, 10, 700, 20, 650, 300, 5);
        tri_y   = pk(10, -5, 100, 10, 10, 500, 5);
        tri_z   = pk(10, 10, 100, 10, 10, 100, -1);

        in_bus.valid    = 1'b0;
        in_bus.vertices = '0;
        in_bus.color    = '0;
        out_bus.ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_bus.ready, 0);
        chk("rst_out_valid", out_bus.valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_out_data", {out_bus.vertices, out_bus.color}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_in_ready", in_bus.ready, 1);
        @(negedge clk);

        // Latency and mode latching, head held with out_ready low
        in_bus.valid    = 1'b1;
        in_bus.vertices = tri_a;
        in_bus.color    = 24'hABCDEF;
        cull_mode       = 2'd0;
        exp_q.push_back({tri_a, 24'hABCDEF});
        @(negedge clk);
        in_bus.valid = 1'b0;
        cull_mode    = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lat_ready_lo", in_bus.ready, 0);
            chk("lat_valid_lo", out_bus.valid, 0);
            @(negedge clk);
        end
        #1;
        chk("lat_valid_hi", out_bus.valid, 1);
        chk("lat_vertices", out_bus.vertices, tri_a);
        chk("lat_color", out_bus.color, 24'hABCDEF);
        chk("lat_drop", drop_count, 0);
        @(negedge clk);
        out_bus.ready = 1'b1;
        drain("lat_drain");

        // Trivially outside: dropped
        send(tri_off, 24'h000001, 2'd0, 1'b1, '0);
        drain("off_drain");
        chk("off_drop", drop_count, exp_drop);
        chk("off_valid", out_bus.valid, 0);
        send(tri_z, 24'h000002, 2'd0, 1'b1, '0);
        drain("z_drain");
        chk("z_drop", drop_count, exp_drop);

        // Partial visibility: clamped
        send(tri_p, 24'h000003, 2'd0, 1'b0,
             pk(600, 10, 639, 20, 639, 300, 5));
        send(tri_y, 24'h000004, 2'd0, 1'b0,
             pk(10, 0, 100, 10, 10, 479, 5));
        drain("clamp_drain");

        // Facing cull
        send(tri_b, 24'h000010, 2'd1, 1'b1, '0);
        send(tri_b, 24'h000011, 2'd2, 1'b0, tri_b);
        send(tri_b, 24'h000012, 2'd0, 1'b0, tri_b);
        send(tri_b, 24'h000013, 2'd3, 1'b0, tri_b);
        send(tri_a, 24'h000014, 2'd1, 1'b0, tri_a);
        send(tri_a, 24'h000015, 2'd2, 1'b1, '0);
        send(tri_c, 24'h000016, 2'd1, 1'b1, '0);
        send(tri_c, 24'h000017, 2'd0, 1'b0, tri_c);
        send(tri_c, 24'h000018, 2'd3, 1'b0, tri_c);
        drain("cull_drain");
        chk("cull_drop", drop_count, exp_drop);

        // FIFO full: fifth triangle waits in PUSH
        out_bus.ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(tri_a, KW'(32'h100 + i), 2'd0, 1'b0, tri_a);
        repeat (6) @(negedge clk);
        #1;
        chk("full_ready", in_bus.ready, 0);
        chk("full_valid", out_bus.valid, 1);
        chk("full_head", out_bus.color, 24'h000100);
        @(negedge clk);
        out_bus.ready = 1'b1;
        @(negedge clk);
        out_bus.ready = 1'b0;
        #1;
        chk("full_blocked", in_bus.ready, 0);
        chk("full_new_head", out_bus.color, 24'h000101);
        @(negedge clk);
        #1;
        chk("full_written", in_bus.ready, 1);
        @(negedge clk);
        out_bus.ready = 1'b1;
        drain("full_drain");

        // Drop counter saturation
        while (exp_drop != MAXD)
            send(tri_off, 24'h0, 2'd0, 1'b1, '0);
        drain("sat_drain");
        chk("sat_max", drop_count, MAXD);
        send(tri_off, 24'h0, 2'd0, 1'b1, '0);
        drain("sat_drain2");
        chk("sat_hold", drop_count, MAXD);
        send(tri_off, 24'h0, 2'd0, 1'b1, '0);
        drop_clear = 1'b1;
        @(negedge clk);
        drop_clear = 1'b0;
        exp_drop = '0;
        drain("clr_drain");
        chk("clr_coincident", drop_count, exp_drop);
        send(tri_off, 24'h0, 2'd0, 1'b1, '0);
        drain("clr_drain2");
        chk("clr_resume", drop_count, exp_drop);

        // Reset during FACING with two entries queued
        out_bus.ready = 1'b0;
        send(tri_a, 24'h000200, 2'd0, 1'b0, tri_a);
        send(tri_b, 24'h000201, 2'd0, 1'b0, tri_b);
        send(tri_a, 24'h000202, 2'd0, 1'b0, tri_a);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", out_bus.valid, 1);
        n_rst = 1'b0;
        exp_q.delete();
        exp_drop = '0;
        #1;
        chk("mid_rst_valid", out_bus.valid, 0);
        chk("mid_rst_ready", in_bus.ready, 0);
        chk("mid_rst_drop", drop_count, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", in_bus.ready, 1);
        chk("post_rst_valid", out_bus.valid, 0);
        @(negedge clk);
        out_bus.ready = 1'b1;
        send(tri_b, 24'h000300, 2'd2, 1'b0, tri_b);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
